// File: rtl/bless_nic_pkg.sv
// bless_nic_pkg: shared field widths, router control-word layout, FIFO entry
// structs and the field-slice helpers used by the NIC and its bench.
// Control word, MSB first: {valid, seq[3], src[4], dest[4], age[4]}.
package bless_nic_pkg;
  localparam int SEQ_N  = 3;
  localparam int ADDR_N = 4;
  localparam int AGE_N  = 4;
  localparam int DATA_N = 8;
  localparam int CTRL_N = 1 + SEQ_N + 2 * ADDR_N + AGE_N;

  localparam int AGE_LO  = 0;
  localparam int DEST_LO = AGE_LO + AGE_N;
  localparam int SRC_LO  = DEST_LO + ADDR_N;
  localparam int SEQ_LO  = SRC_LO + ADDR_N;
  localparam int VLD_B   = SEQ_LO + SEQ_N;

  typedef logic [CTRL_N-1:0] ctrl_t;

  typedef struct packed {
    logic [ADDR_N-1:0] dest;
    logic [DATA_N-1:0] data;
    logic [SEQ_N-1:0]  seq;
  } inj_ent_t;

  typedef struct packed {
    logic [ADDR_N-1:0] src;
    logic [SEQ_N-1:0]  seq;
    logic [DATA_N-1:0] data;
  } ej_ent_t;

  function automatic logic valid_f(input ctrl_t c);
    return c[VLD_B];
  endfunction

  function automatic logic [SEQ_N-1:0] seq_f(input ctrl_t c);
    return c[SEQ_LO +: SEQ_N];
  endfunction

  function automatic logic [ADDR_N-1:0] src_f(input ctrl_t c);
    return c[SRC_LO +: ADDR_N];
  endfunction

  function automatic logic [ADDR_N-1:0] dest_f(input ctrl_t c);
    return c[DEST_LO +: ADDR_N];
  endfunction

  function automatic logic [AGE_N-1:0] age_f(input ctrl_t c);
    return c[AGE_LO +: AGE_N];
  endfunction

  function automatic ctrl_t pack_ctrl(input logic v, input logic [SEQ_N-1:0] seq,
                                      input logic [ADDR_N-1:0] src,
                                      input logic [ADDR_N-1:0] dest,
                                      input logic [AGE_N-1:0] age);
    return {v, seq, src, dest, age};
  endfunction
endpackage

// File: rtl/bless_nic_if.sv
// bless_nic_if: bundles the core-side injection/ejection handshakes and the
// router local port (port4). Modport slave is the NIC side, master is the
// core/router environment driving it.
interface bless_nic_if;
  import bless_nic_pkg::*;

  logic              inj_valid;
  logic              inj_ready;
  logic [ADDR_N-1:0] inj_dest;
  logic [DATA_N-1:0] inj_data;
  logic              port4_ready;
  ctrl_t             port4_ci;
  logic [DATA_N-1:0] port4_di;
  ctrl_t             port4_co;
  logic [DATA_N-1:0] port4_do;
  logic              ej_valid;
  logic              ej_ready;
  logic [ADDR_N-1:0] ej_src;
  logic [SEQ_N-1:0]  ej_seq;
  logic [DATA_N-1:0] ej_data;
  logic              ej_drop;
  logic [7:0]        drop_cnt;

  modport slave (
    input  inj_valid, inj_dest, inj_data, port4_ready, port4_co, port4_do, ej_ready,
    output inj_ready, port4_ci, port4_di, ej_valid, ej_src, ej_seq, ej_data,
           ej_drop, drop_cnt
  );

  modport master (
    output inj_valid, inj_dest, inj_data, port4_ready, port4_co, port4_do, ej_ready,
    input  inj_ready, port4_ci, port4_di, ej_valid, ej_src, ej_seq, ej_data,
           ej_drop, drop_cnt
  );
endinterface

// File: rtl/bless_nic_fifo.sv
// nic_fifo: small synchronous FIFO.
// Ports: clk, rst (sync, active-low), push/din, pop/dout (head, show-ahead),
// full, empty. A push while full is accepted only when a pop happens on the
// same edge; pop on empty is ignored. DEPTH must be a power of two.
module nic_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: contents are only visible through gated outputs.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/bless_nic.sv
// bless_nic: network interface between a core and the local port of a
// bufferless deflection router.
// Ports: clk, rst (sync, active-low), bus (bless_nic_if.slave):
//   injection  inj_valid/inj_ready/inj_dest/inj_data -> port4_ci/port4_di
//   ejection   port4_co/port4_do -> ej_valid/ej_ready/ej_src/ej_seq/ej_data
//   drops      ej_drop pulse, drop_cnt saturating counter
module bless_nic
  import bless_nic_pkg::*;
#(
  parameter logic [ADDR_N-1:0] NODE_ID    = 4'd0,
  parameter int                FIFO_DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  bless_nic_if.slave bus
);
  // ---------------- injection path ----------------
  inj_ent_t          inj_din, inj_head;
  logic              inj_full, inj_empty, inj_push, inj_pop;
  logic [SEQ_N-1:0]  seq_ctr;
  logic [AGE_N-1:0]  head_age;

  assign bus.inj_ready = ~inj_full;
  assign inj_push      = bus.inj_valid & ~inj_full;
  // The router gives no acknowledge: presenting a flit while port4_ready is
  // high is the transfer, so the pop is unconditional.
  assign inj_pop       = ~inj_empty & bus.port4_ready;
  assign inj_din       = '{dest: bus.inj_dest, data: bus.inj_data, seq: seq_ctr};

  nic_fifo #(.WIDTH($bits(inj_ent_t)), .DEPTH(FIFO_DEPTH)) u_inj_fifo (
    .clk(clk), .rst(rst), .push(inj_push), .din(inj_din), .pop(inj_pop),
    .dout(inj_head), .full(inj_full), .empty(inj_empty)
  );

  assign bus.port4_ci = inj_pop ? pack_ctrl(1'b1, inj_head.seq, NODE_ID, inj_head.dest, head_age)
                                : '0;
  assign bus.port4_di = inj_pop ? inj_head.data : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      seq_ctr  <= '0;
      head_age <= '0;
    end else begin
      if (inj_push) seq_ctr <= seq_ctr + SEQ_N'(1);
      // Age tracks how long the current head has waited for the router.
      if (inj_pop)
        head_age <= '0;
      else if (!inj_empty && head_age != '1)
        head_age <= head_age + AGE_N'(1);
    end
  end

  // ---------------- ejection path ----------------
  ej_ent_t ej_din, ej_head;
  logic    ej_full, ej_empty, ej_push, ej_pop, co_valid, for_me, drop;
  logic    unused_co_age;

  assign co_valid      = valid_f(bus.port4_co);
  assign for_me        = (dest_f(bus.port4_co) == NODE_ID);
  assign unused_co_age = ^age_f(bus.port4_co);
  assign ej_pop        = ~ej_empty & bus.ej_ready;
  // The router cannot be stalled, so a flit with nowhere to go is lost.
  assign ej_push       = co_valid & for_me & (~ej_full | ej_pop);
  assign drop          = co_valid & ~ej_push;
  assign ej_din        = '{src: src_f(bus.port4_co), seq: seq_f(bus.port4_co),
                           data: bus.port4_do};

  nic_fifo #(.WIDTH($bits(ej_ent_t)), .DEPTH(FIFO_DEPTH)) u_ej_fifo (
    .clk(clk), .rst(rst), .push(ej_push), .din(ej_din), .pop(ej_pop),
    .dout(ej_head), .full(ej_full), .empty(ej_empty)
  );

  assign bus.ej_valid = ~ej_empty;
  assign bus.ej_src   = ej_empty ? '0 : ej_head.src;
  assign bus.ej_seq   = ej_empty ? '0 : ej_head.seq;
  assign bus.ej_data  = ej_empty ? '0 : ej_head.data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.ej_drop  <= 1'b0;
      bus.drop_cnt <= '0;
    end else begin
      bus.ej_drop <= drop;
      if (drop && bus.drop_cnt != 8'hFF) bus.drop_cnt <= bus.drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_bless_nic.sv
// tb_bless_nic: directed scenarios plus a randomized run checked against a
// queue-based model of the NIC's injection and ejection behaviour.
module tb_bless_nic;
  localparam logic [3:0] NODE  = 4'd5;
  localparam int         DEPTH = 4;

  logic clk, rst;
  bless_nic_if bus();

  bless_nic #(.NODE_ID(NODE), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  typedef struct { logic [3:0] dest; logic [7:0] data; logic [2:0] seq; } m_inj_t;
  typedef struct { logic [3:0] src;  logic [2:0] seq;  logic [7:0] data; } m_ej_t;
  m_inj_t iq[$];
  m_ej_t  eq[$];
  int m_seq = 0, m_age = 0, m_cnt = 0;
  bit m_drop = 0;

  task automatic model_edge();
    bit ipop, ipush, epop, cap, keep;
    if (!rst) begin
      iq.delete(); eq.delete();
      m_seq = 0; m_age = 0; m_cnt = 0; m_drop = 0;
    end else begin
      ipop  = (iq.size() > 0) && bus.port4_ready;
      ipush = bus.inj_valid && (iq.size() < DEPTH);
      epop  = (eq.size() > 0) && bus.ej_ready;
      cap   = bus.port4_co[15];
      keep  = cap && (bus.port4_co[7:4] == NODE) && ((eq.size() < DEPTH) || epop);
      if (ipop) begin
        void'(iq.pop_front());
        m_age = 0;
      end else if (iq.size() > 0) begin
        m_age = (m_age < 15) ? m_age + 1 : 15;
      end
      if (ipush) begin
        iq.push_back('{bus.inj_dest, bus.inj_data, m_seq[2:0]});
        m_seq = (m_seq + 1) % 8;
      end
      if (epop) void'(eq.pop_front());
      if (keep) eq.push_back('{bus.port4_co[11:8], bus.port4_co[14:12], bus.port4_do});
      m_drop = cap && !keep;
      if (m_drop && m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.inj_valid = 0; bus.inj_dest = 0; bus.inj_data = 0;
    bus.port4_ready = 0; bus.port4_co = 0; bus.port4_do = 0; bus.ej_ready = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [49:0] got;
    rst = 0; idle_inputs();
    tick(); tick();
    rst = 1;
    #1;
    got = {bus.inj_ready, bus.port4_ci, bus.port4_di, bus.ej_valid, bus.ej_src,
           bus.ej_seq, bus.ej_data, bus.ej_drop, bus.drop_cnt};
    n_chk++;
    if (got !== {1'b1, 49'd0}) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", got, {1'b1, 49'd0});
    end
  endtask

  task automatic test_inject_burst();
    logic [23:0] exp;
    bus.port4_ready = 1;
    for (int i = 0; i < 6; i++) begin
      bus.inj_valid = (i < 3);
      bus.inj_dest  = 4'(i + 1);
      bus.inj_data  = 8'(8'hA0 + i);
      #1;
      n_chk++;
      if (i >= 1 && i <= 3) begin
        exp = {1'b1, 3'(i - 1), NODE, 4'(i), 4'd0, 8'(8'hA0 + i - 1)};
        if ({bus.port4_ci, bus.port4_di} !== exp) begin
          n_fail++; $display("FAIL burst_flit%0d: got %h expected %h", i, {bus.port4_ci, bus.port4_di}, exp);
        end
      end else if (bus.port4_ci[15] !== 1'b0) begin
        n_fail++; $display("FAIL burst_idle%0d: got valid %b expected 0", i, bus.port4_ci[15]);
      end
      tick();
    end
    bus.inj_valid = 0;
  endtask

  task automatic test_age_saturate();
    logic [23:0] exp;
    bus.port4_ready = 0;
    bus.inj_valid = 1; bus.inj_dest = 4'd7; bus.inj_data = 8'h11; tick();
    bus.inj_dest = 4'd8; bus.inj_data = 8'h22; tick();
    bus.inj_valid = 0;
    repeat (20) tick();
    bus.port4_ready = 1;
    #1;
    exp = {1'b1, 3'd3, NODE, 4'd7, 4'd15, 8'h11};
    n_chk++;
    if ({bus.port4_ci, bus.port4_di} !== exp) begin
      n_fail++; $display("FAIL age_saturated: got %h expected %h", {bus.port4_ci, bus.port4_di}, exp);
    end
    tick();
    exp = {1'b1, 3'd4, NODE, 4'd8, 4'd0, 8'h22};
    n_chk++;
    if ({bus.port4_ci, bus.port4_di} !== exp) begin
      n_fail++; $display("FAIL age_cleared: got %h expected %h", {bus.port4_ci, bus.port4_di}, exp);
    end
    tick();
    n_chk++;
    if (bus.port4_ci[15] !== 1'b0) begin
      n_fail++; $display("FAIL age_empty: got valid %b expected 0", bus.port4_ci[15]);
    end
  endtask

  task automatic test_fill();
    logic [24:0] exp;
    logic [2:0]  seqs [4];
    seqs = '{3'd6, 3'd7, 3'd0, 3'd1};
    bus.port4_ready = 0;
    for (int i = 0; i < 4; i++) begin
      bus.inj_valid = 1; bus.inj_dest = 4'd2; bus.inj_data = 8'(8'h30 + i);
      tick();
    end
    bus.inj_valid = 0;
    #1;
    n_chk++;
    if ({bus.inj_ready, bus.port4_ci[15]} !== 2'b00) begin
      n_fail++; $display("FAIL fill_full: got %b expected 00", {bus.inj_ready, bus.port4_ci[15]});
    end
    // Offer a flit while full and release the router on the same edge.
    bus.inj_valid = 1; bus.inj_data = 8'h34; bus.port4_ready = 1;
    #1;
    exp = {1'b0, 1'b1, 3'd5, NODE, 4'd2, 4'd3, 8'h30};
    n_chk++;
    if ({bus.inj_ready, bus.port4_ci, bus.port4_di} !== exp) begin
      n_fail++; $display("FAIL fill_head: got %h expected %h", {bus.inj_ready, bus.port4_ci, bus.port4_di}, exp);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) bus.inj_valid = 0;
      #1;
      exp = {1'b1, 1'b1, seqs[k], NODE, 4'd2, 4'd0, 8'(8'h31 + k)};
      n_chk++;
      if ({bus.inj_ready, bus.port4_ci, bus.port4_di} !== exp) begin
        n_fail++; $display("FAIL fill_drain%0d: got %h expected %h", k, {bus.inj_ready, bus.port4_ci, bus.port4_di}, exp);
      end
      tick();
    end
    n_chk++;
    if ({bus.inj_ready, bus.port4_ci[15]} !== 2'b10) begin
      n_fail++; $display("FAIL fill_empty: got %b expected 10", {bus.inj_ready, bus.port4_ci[15]});
    end
    bus.inj_valid = 0;
  endtask

  task automatic test_eject_overflow();
    logic [15:0] exp;
    bus.ej_ready = 0;
    for (int i = 0; i < 5; i++) begin
      bus.port4_co = {1'b1, 3'(i), 4'(i + 1), NODE, 4'd0};
      bus.port4_do = 8'(8'h50 + i);
      tick();
      n_chk++;
      if ({bus.ej_valid, bus.ej_drop} !== {1'b1, (i == 4)}) begin
        n_fail++; $display("FAIL ovf_capture%0d: got %b expected %b", i, {bus.ej_valid, bus.ej_drop}, {1'b1, (i == 4)});
      end
    end
    bus.port4_co = 0;
    tick();
    n_chk++;
    if ({bus.ej_drop, bus.drop_cnt} !== {1'b0, 8'd1}) begin
      n_fail++; $display("FAIL ovf_count: got %h expected %h", {bus.ej_drop, bus.drop_cnt}, {1'b0, 8'd1});
    end
    bus.ej_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp = {1'b1, 4'(k + 1), 3'(k), 8'(8'h50 + k)};
      n_chk++;
      if ({bus.ej_valid, bus.ej_src, bus.ej_seq, bus.ej_data} !== exp) begin
        n_fail++; $display("FAIL ovf_drain%0d: got %h expected %h", k, {bus.ej_valid, bus.ej_src, bus.ej_seq, bus.ej_data}, exp);
      end
      tick();
    end
    n_chk++;
    if ({bus.ej_valid, bus.ej_src, bus.ej_seq, bus.ej_data} !== 16'd0) begin
      n_fail++; $display("FAIL ovf_empty: got %h expected 0", {bus.ej_valid, bus.ej_src, bus.ej_seq, bus.ej_data});
    end
  endtask

  task automatic test_misroute();
    bus.ej_ready = 1;
    bus.port4_co = {1'b1, 3'd0, 4'd3, NODE ^ 4'd1, 4'd0};
    bus.port4_do = 8'h77;
    tick();
    n_chk++;
    if ({bus.ej_valid, bus.ej_drop, bus.drop_cnt} !== {2'b01, 8'd2}) begin
      n_fail++; $display("FAIL misroute_one: got %h expected %h", {bus.ej_valid, bus.ej_drop, bus.drop_cnt}, {2'b01, 8'd2});
    end
    repeat (299) tick();
    bus.port4_co = 0;
    tick();
    n_chk++;
    if ({bus.ej_valid, bus.ej_drop, bus.drop_cnt} !== {2'b00, 8'd255}) begin
      n_fail++; $display("FAIL misroute_sat: got %h expected %h", {bus.ej_valid, bus.ej_drop, bus.drop_cnt}, {2'b00, 8'd255});
    end
  endtask

  task automatic test_random();
    logic [23:0] exp_ci;
    logic [15:0] exp_ej;
    logic [3:0]  d;
    bit          exp_cv;
    rst = 0; idle_inputs(); tick(); rst = 1;
    for (int c = 0; c < 400; c++) begin
      bus.inj_valid   = ($urandom_range(0, 9) < 6);
      bus.inj_dest    = 4'($urandom);
      bus.inj_data    = 8'($urandom);
      bus.port4_ready = ($urandom_range(0, 9) < 5);
      bus.ej_ready    = ($urandom_range(0, 9) < 4);
      d = ($urandom_range(0, 3) != 0) ? NODE : 4'($urandom);
      bus.port4_co = {1'($urandom), 3'($urandom), 4'($urandom), d, 4'($urandom)};
      bus.port4_do = 8'($urandom);
      #1;
      exp_cv = (iq.size() > 0) && bus.port4_ready;
      n_chk++;
      if ({bus.inj_ready, bus.port4_ci[15]} !== {(iq.size() < DEPTH), exp_cv}) begin
        n_fail++; $display("FAIL rnd_inj_hs c%0d: got %b expected %b", c, {bus.inj_ready, bus.port4_ci[15]}, {(iq.size() < DEPTH), exp_cv});
      end
      if (exp_cv) begin
        exp_ci = {1'b1, iq[0].seq, NODE, iq[0].dest, 4'(m_age), iq[0].data};
        n_chk++;
        if ({bus.port4_ci, bus.port4_di} !== exp_ci) begin
          n_fail++; $display("FAIL rnd_inj_flit c%0d: got %h expected %h", c, {bus.port4_ci, bus.port4_di}, exp_ci);
        end
      end
      exp_ej = (eq.size() > 0) ? {1'b1, eq[0].src, eq[0].seq, eq[0].data} : 16'd0;
      n_chk++;
      if ({bus.ej_valid, bus.ej_src, bus.ej_seq, bus.ej_data} !== exp_ej) begin
        n_fail++; $display("FAIL rnd_ej_head c%0d: got %h expected %h", c, {bus.ej_valid, bus.ej_src, bus.ej_seq, bus.ej_data}, exp_ej);
      end
      n_chk++;
      if ({bus.ej_drop, bus.drop_cnt} !== {m_drop, 8'(m_cnt)}) begin
        n_fail++; $display("FAIL rnd_drop c%0d: got %h expected %h", c, {bus.ej_drop, bus.drop_cnt}, {m_drop, 8'(m_cnt)});
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [49:0] got;
    rst = 0; idle_inputs(); tick(); rst = 1;
    bus.inj_valid = 1; bus.inj_dest = 4'd9; bus.inj_data = 8'hC1;
    bus.port4_co = {1'b1, 3'd1, 4'd2, NODE, 4'd0}; bus.port4_do = 8'hD1;
    tick(); tick();
    bus.inj_valid = 0;
    bus.port4_co = {1'b1, 3'd1, 4'd2, NODE ^ 4'd2, 4'd0};
    tick();
    bus.port4_co = 0;
    #1;
    n_chk++;
    if ({bus.inj_ready, bus.ej_valid, bus.drop_cnt} !== {2'b11, 8'd1}) begin
      n_fail++; $display("FAIL mid_preload: got %h expected %h", {bus.inj_ready, bus.ej_valid, bus.drop_cnt}, {2'b11, 8'd1});
    end
    rst = 0; bus.port4_ready = 1; bus.ej_ready = 1;
    tick();
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      got = {bus.inj_ready, bus.port4_ci, bus.port4_di, bus.ej_valid, bus.ej_src,
             bus.ej_seq, bus.ej_data, bus.ej_drop, bus.drop_cnt};
      n_chk++;
      if (got !== {1'b1, 49'd0}) begin
        n_fail++; $display("FAIL mid_reset%0d: got %h expected %h", k, got, {1'b1, 49'd0});
      end
      tick();
    end
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    test_reset();
    test_inject_burst();
    test_age_saturate();
    test_fill();
    test_eject_overflow();
    test_misroute();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bless_nic.md
BLESS_NIC -- requirements
Module: bless_nic

Interface
REQ-001 Parameter NODE_ID, default 4'd0: this node's 4-bit address, driven on src and matched against dest.
REQ-002 Parameter FIFO_DEPTH, default 4: entries in each of the injection and ejection FIFOs; power of two, 2..16.
REQ-003 clk  in  1  the single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-low: state clears on a posedge clk while rst=0.
REQ-005 inj_valid  in  1  core offers a flit.
REQ-006 inj_ready  out  1  injection FIFO not full.
REQ-007 inj_dest  in  4  destination address of the offered flit.
REQ-008 inj_data  in  8  payload of the offered flit.
REQ-009 port4_ready  in  1  router accepts a local injection this cycle.
REQ-010 port4_ci  out  16  control to router: {valid, seq[3], src[4], dest[4], age[4]}, MSB first.
REQ-011 port4_di  out  8  data to router.
REQ-012 port4_co  in  16  control ejected by router, same field layout.
REQ-013 port4_do  in  8  data ejected by router.
REQ-014 ej_valid  out  1  ejection FIFO not empty.
REQ-015 ej_ready  in  1  core consumes the ejection head.
REQ-016 ej_src, ej_seq, ej_data  out  4/3/8  fields of the ejection head.
REQ-017 ej_drop  out  1  one-cycle pulse: a valid ejected flit was discarded.
REQ-018 drop_cnt  out  8  saturating count of discarded ejected flits.

Function
REQ-019 Injection push SHALL occur on a clock edge where inj_valid=1 and inj_ready=1; it stores {inj_dest, inj_data, seq_ctr} and increments seq_ctr mod 8 (7->0).
REQ-020 port4_ci[valid] SHALL equal inj FIFO non-empty AND port4_ready, combinationally; other fields SHALL come from the FIFO head, with src=NODE_ID and age=head_age.
REQ-021 Injection pop SHALL occur on an edge where port4_ci[valid]=1; router acceptance is implied, so there is no retry.
REQ-022 head_age SHALL increment by 1 each cycle the FIFO is non-empty and not popped, saturate at 15, and clear to 0 on pop.
REQ-023 When the FIFO is full, a simultaneous push and pop SHALL both succeed; inj_ready SHALL reflect pre-edge occupancy only.
REQ-024 An ejected flit (port4_co[valid]=1) SHALL be captured in the cycle it is presented; the router is bufferless and cannot be stalled.
REQ-025 A captured flit with dest==NODE_ID SHALL be pushed into the ejection FIFO as {src, seq, data}, unless the FIFO is full and not popped that edge.
REQ-026 A flit SHALL be dropped, with ej_drop=1 on the next cycle and drop_cnt+1 (saturating at 255), when the ejection FIFO is full with no pop, or when dest!=NODE_ID.
REQ-027 Ejection pop SHALL occur on an edge where ej_valid=1 and ej_ready=1; push and pop at full SHALL both succeed.
REQ-028 Latency: an inject push at edge N SHALL make port4_ci[valid] possible in cycle N+1 (empty FIFO); an eject capture at edge N SHALL give ej_valid=1 in cycle N+1.
REQ-029 Injection and ejection paths SHALL operate concurrently and independently in every cycle.

Reset
REQ-030 While rst=0 at an edge, the block SHALL clear: both FIFOs to empty, seq_ctr=0, head_age=0, drop_cnt=0, ej_drop=0.
REQ-031 Resulting outputs after reset: inj_ready=1, port4_ci=0, port4_di=0, ej_valid=0.
REQ-032 ej_src, ej_seq and ej_data SHALL be 0 when ej_valid=0.
REQ-033 Reset mid-operation SHALL discard all queued flits without emitting them; port4_ci[valid] SHALL be 0 from the first cycle after the reset edge.

Structure
REQ-034 Field widths (SEQ_N=3, ADDR_N=4, AGE_N=4, DATA_N=8) and field-slice macros (valid_f, seq_f, src_f, dest_f, age_f) SHALL live in the shared defines file.
REQ-035 One sub-module, nic_fifo (parameters width and depth; synchronous, active-low reset; push/pop/full/empty), SHALL be instantiated twice.

Verification
REQ-036 Push 3 flits (dest 1, 2, 3) with port4_ready=1 -> port4_ci valid on 3 consecutive cycles, seq 0/1/2, src=NODE_ID, age 0.
REQ-037 One flit queued, port4_ready=0 for 20 cycles -> on release, age=15 (saturated); after the pop the next head shows age 0.
REQ-038 Fill the injection FIFO (4 flits) -> inj_ready=0; push and pop on the same edge -> count stays 4, no loss; 9 total pushes -> seq wraps 7->0.
REQ-039 Eject 5 flits to NODE_ID with ej_ready=0 -> 4 stored, the fifth drops, ej_drop pulses once, drop_cnt=1; drain -> order preserved.
REQ-040 Eject a flit with dest!=NODE_ID -> dropped, drop_cnt increments; 300 such drops -> drop_cnt=255.
REQ-041 Assert rst=0 with both FIFOs holding 2 flits -> next cycle all outputs per REQ-031, drop_cnt=0.
